// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall FSM, instruction-memory conflict
// and taken-branch flush, sticky fetch-error hold and a load-use stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W    = 4,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter logic [REG_W-1:0] NOREG = {REG_W{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*REG_W-1:0] id_read_regs,
  input  logic [NREAD-1:0]       id_read_en,
  input  logic [REG_W-1:0]       ex_write_reg,
  input  logic                   ex_mem_read,
  input  logic                   mem_if_conflict,
  input  logic                   branch_taken,
  input  logic                   error,
  input  logic                   error_clr,
  output logic                   pc_keep,
  output logic                   if_keep,
  output logic                   id_keep,
  output logic                   ex_bubble,
  output logic                   if_flush,
  output logic                   err_hold,
  output logic [15:0]            stall_cnt
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } stateT;

  stateT            state;
  logic [CNT_W-1:0] cnt;
  logic             srcMatch;
  logic             hit;
  logic             stall;
  logic             conflict;
  logic             branchQual;

  // Any enabled ID source register equal to the EX destination.
  always_comb begin
    srcMatch = 1'b0;
    for (int k = 0; k < int'(NREAD); k++) begin
      if (id_read_en[k] && (id_read_regs[k*REG_W +: REG_W] == ex_write_reg)) begin
        srcMatch = 1'b1;
      end
    end
  end

  assign hit        = ex_mem_read && (ex_write_reg != NOREG) && srcMatch;
  assign stall      = (state == LU_STALL) || hit;
  assign conflict   = mem_if_conflict && !stall;
  assign branchQual = branch_taken && !stall;

  assign pc_keep   = stall || conflict || err_hold || error;
  assign if_keep   = stall || err_hold || error;
  assign id_keep   = stall;
  assign ex_bubble = stall;
  assign if_flush  = conflict || branchQual;

  // The RUN cycle that detects the hit is the first stall cycle, so the
  // LU_STALL state only covers the remaining LOAD_LAT-1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      err_hold  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (hit && (LOAD_LAT > 1)) begin
            state <= LU_STALL;
            cnt   <= CNT_INIT;
          end
        end
        LU_STALL: begin
          if (cnt <= CNT_W'(1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase

      if (error) begin
        err_hold <= 1'b1;
      end else if (error_clr) begin
        err_hold <= 1'b0;
      end

      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule
